mu0_sequencer: RTL and testbench
================================

# mu0_sequencer

Instruction sequencer and fetch/decode stage for the MU0 CPU core, sitting directly upstream of the ALU. It owns the program counter, instruction register, operand register and FETCH/EXEC1/EXEC2/HALT state machine. It drives `instruction`, `exec1` and `exec2` into the ALU, and executes MU0 memory, jump and stop opcodes itself. Non-MU0 (register/ARM-style) opcodes pass to the ALU as single-exec-cycle instructions.

## Interface
- `PC_WIDTH`, 12, width of program counter and memory address.
- `RESET_PC`, 0, PC value loaded on reset.

- `clk`  in  1  single clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `memdata`  in  16  memory read data; combinational (asynchronous) read of `addr`.
- `accdata`  in  16  accumulator value, used for JMI/JEQ conditions.
- `skipstatus`  in  1  Q of the SKIP flip-flop; 1 marks the current instruction as squashed.
- `instruction`  out  16  IR contents, fed to the ALU.
- `fetch`, `exec1`, `exec2`  out  1 each  one-hot state strobes, all 0 in HALT.
- `pc`  out  PC_WIDTH  program counter.
- `addr`  out  PC_WIDTH  memory address.
- `memwr`  out  1  memory write strobe; write data is `accdata`, committed on the clock edge.
- `operand`  out  16  operand register, valid in EXEC2.
- `accwen`  out  1  accumulator write enable for LDA/ADD/SUB.
- `halted`  out  1  1 while in HALT.

## Operation
- Opcode = `instruction[15:12]`.
  - MU0 set: LDA 0, STA 1, ADD 2, SUB 3, JMP 4, JMI 5, JEQ 6, STP 7, LDI 8, LSL 9, LSR A.
  - Opcodes B–F are non-MU0.
- **FETCH:** `addr`=`pc`. At the edge: IR←`memdata`, `pc`←`pc`+1 modulo 2^PC_WIDTH (0xFFF wraps to 0x000). Next state EXEC1.
- **EXEC1:**
  - LDA/ADD/SUB: `addr`=IR[11:0]; operand←`memdata`; next state EXEC2.
  - STA: `addr`=IR[11:0]; `memwr`=1.
  - JMP: `pc`←IR[11:0].
  - JMI: `pc`←IR[11:0] if `accdata[15]`=1.
  - JEQ: `pc`←IR[11:0] if `accdata`=0.
  - STP: next state HALT.
  - All other opcodes: no sequencer action; ALU acts in this cycle.
  - Next state is FETCH unless EXEC2 or HALT is stated above.
- **EXEC2:** `accwen`=1; `operand` held. Next state FETCH.
- **HALT:** sticky until `reset`. `pc`, IR and operand frozen; `memwr`=`accwen`=0.
- **Skip:** if `skipstatus`=1 in EXEC1/EXEC2, suppress the instruction's effects:
  - `memwr`=0, `accwen`=0, no PC load, and STP does not halt.
  - State sequence is unchanged: LDA/ADD/SUB still pass through EXEC2, so the ALU clears SKIP on the instruction's final exec cycle.
- When the state is not EXEC1/EXEC2 of a memory-operand op, `addr`=`pc`.

## Timing
- Reset (synchronous): state←FETCH, `pc`←RESET_PC, IR←0, operand←0.
  - During and immediately after the reset cycle: `fetch`=1, `exec1`=`exec2`=0, `memwr`=`accwen`=0, `halted`=0, `instruction`=0, `addr`=RESET_PC.
- Reset has priority over every transition, including HALT and mid-instruction (EXEC1/EXEC2). No partial write occurs in the reset cycle.
- Cycle counts:
  - LDA/ADD/SUB: 3 cycles (FETCH, EXEC1, EXEC2).
  - All other opcodes: 2 cycles.
  - STP: 2 cycles, then HALT from cycle 3 on.
- All outputs decode combinationally from state, IR and `skipstatus`. `pc`, IR and operand are registered.
- Jump targets are visible on `pc` the cycle after EXEC1, so the next FETCH reads the target.
- JMI/JEQ sample `accdata` in EXEC1. A write to the accumulator in the same cycle is not seen.

## Test plan
- **Reset/fetch:** reset high 2 cycles, memory[0]=0x0005 (LDA 5), memory[5]=0x1234, release.
  - Expect `fetch` at cycle 0, `exec1` with `addr`=0x005 at cycle 1.
  - Expect `exec2` with `operand`=0x1234 and `accwen`=1 at cycle 2, `pc`=0x001.
- **Store:** IR=0x1010 (STA 0x010), `accdata`=0xBEEF.
  - Expect `memwr`=1 and `addr`=0x010 in EXEC1 only, then FETCH at `addr`=0x001.
- **Conditional jumps:** JEQ 0x020 with `accdata`=0 → `pc`=0x020. With `accdata`=0x0001 → `pc` unchanged.
  - JMI 0x030 with `accdata`=0x8000 → `pc`=0x030.
- **Skip:** `skipstatus`=1 during ADD 0x007.
  - Expect EXEC1 and EXEC2 strobes to occur, `accwen`=0 throughout, next FETCH normal.
  - Repeat with skipped JMP: `pc` not loaded. Skipped STP: no HALT.
- **Halt and reset:** STP → `halted`=1 and all strobes 0 for ≥10 cycles with `pc` frozen.
  - Assert reset → next cycle `fetch`=1, `pc`=RESET_PC.
  - Assert reset during EXEC1 of STA → `memwr` stays 0.
- **Wrap:** `pc`=0xFFF, non-MU0 opcode 0xC000 → after FETCH `pc`=0x000, one exec cycle, `accwen`=0.

Source files
------------

// File: rtl/mu0_sequencer.sv
// MU0 fetch/decode sequencer: owns PC, IR and operand register, runs the
// FETCH/EXEC1/EXEC2/HALT machine and executes memory, jump and stop opcodes.
module mu0_sequencer #(
  parameter int                    PC_WIDTH = 12,
  parameter logic [PC_WIDTH-1:0]   RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [15:0]         memdata,
  input  logic [15:0]         accdata,
  input  logic                skipstatus,
  output logic [15:0]         instruction,
  output logic                fetch,
  output logic                exec1,
  output logic                exec2,
  output logic [PC_WIDTH-1:0] pc,
  output logic [PC_WIDTH-1:0] addr,
  output logic                memwr,
  output logic [15:0]         operand,
  output logic                accwen,
  output logic                halted
);

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_EXEC1 = 2'd1;
  localparam logic [1:0] S_EXEC2 = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_STA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_JMP = 4'h4;
  localparam logic [3:0] OP_JMI = 4'h5;
  localparam logic [3:0] OP_JEQ = 4'h6;
  localparam logic [3:0] OP_STP = 4'h7;

  logic [1:0]          state;
  logic [1:0]          state_next;
  logic [15:0]         ir;
  logic [3:0]          opcode;
  logic                is_load_op;
  logic                is_mem_op;
  logic                take_jump;
  logic [PC_WIDTH-1:0] target;

  assign opcode     = ir[15:12];
  assign is_load_op = (opcode == OP_LDA) || (opcode == OP_ADD) || (opcode == OP_SUB);
  assign is_mem_op  = is_load_op || (opcode == OP_STA);
  assign target     = PC_WIDTH'(ir[11:0]);

  // Reset overrides the decode so the reset cycle itself already looks like
  // FETCH at RESET_PC and can never commit a store.
  assign fetch       = reset || (state == S_FETCH);
  assign exec1       = !reset && (state == S_EXEC1);
  assign exec2       = !reset && (state == S_EXEC2);
  assign halted      = !reset && (state == S_HALT);
  assign instruction = reset ? 16'h0000 : ir;

  assign memwr  = exec1 && (opcode == OP_STA) && !skipstatus;
  assign accwen = exec2 && !skipstatus;

  assign take_jump = exec1 && !skipstatus &&
                     ((opcode == OP_JMP) ||
                      ((opcode == OP_JMI) && accdata[15]) ||
                      ((opcode == OP_JEQ) && (accdata == 16'h0000)));

  always_comb begin
    if (reset)
      addr = RESET_PC;
    else if ((exec1 && is_mem_op) || (exec2 && is_load_op))
      addr = target;
    else
      addr = pc;
  end

  // NOTE: next_state gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      S_FETCH: state_next = S_EXEC1;
      S_EXEC1: begin
        if (is_load_op)
          state_next = S_EXEC2;
        else if ((opcode == OP_STP) && !skipstatus)
          state_next = S_HALT;
        else
          state_next = S_FETCH;
      end
      S_EXEC2: state_next = S_FETCH;
      default: state_next = S_HALT;
    endcase
  end

  // NOTE: all registered state uses non-blocking assignments so every
  // register samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_FETCH;
      pc      <= RESET_PC;
      ir      <= 16'h0000;
      operand <= 16'h0000;
    end else begin
      state <= state_next;
      if (state == S_FETCH) begin
        ir <= memdata;
        pc <= pc + 1'b1;
      end
      if (take_jump)
        pc <= target;
      if ((state == S_EXEC1) && is_load_op)
        operand <= memdata;
    end
  end

endmodule

// File: tb/tb_mu0_sequencer.sv
// Directed self-checking bench for mu0_sequencer with a behavioural 4K x 16
// memory and bench-driven accumulator/skip inputs.
module tb_mu0_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] memdata;
  logic [15:0] accdata;
  logic        skipstatus;
  logic [15:0] instruction;
  logic        fetch, exec1, exec2;
  logic [11:0] pc;
  logic [11:0] addr;
  logic        memwr;
  logic [15:0] operand;
  logic        accwen;
  logic        halted;

  logic [15:0] mem [0:4095];
  int          n_checks = 0;
  int          n_fail   = 0;

  mu0_sequencer #(.PC_WIDTH(12), .RESET_PC(12'h000)) dut (
    .clk         (clk),
    .reset       (reset),
    .memdata     (memdata),
    .accdata     (accdata),
    .skipstatus  (skipstatus),
    .instruction (instruction),
    .fetch       (fetch),
    .exec1       (exec1),
    .exec2       (exec2),
    .pc          (pc),
    .addr        (addr),
    .memwr       (memwr),
    .operand     (operand),
    .accwen      (accwen),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  assign memdata = mem[addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Commit a pending store with pre-edge values, advance one clock, settle.
  task automatic step();
    if (memwr === 1'b1) mem[addr] = accdata;
    @(posedge clk);
    #1;
  endtask

  task automatic check_strobes(input string tag, input logic f, input logic e1,
                               input logic e2, input logic h);
    check({tag, "_strobes"}, {28'h0, fetch, exec1, exec2, halted}, {28'h0, f, e1, e2, h});
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
    mem[12'h000] = 16'h0005;  // LDA 5
    mem[12'h005] = 16'h1234;
    mem[12'h001] = 16'h1010;  // STA 0x010
    mem[12'h002] = 16'h6020;  // JEQ 0x020
    mem[12'h020] = 16'h6040;  // JEQ 0x040
    mem[12'h021] = 16'h5030;  // JMI 0x030
    mem[12'h030] = 16'h2007;  // ADD 7
    mem[12'h031] = 16'h4100;  // JMP 0x100
    mem[12'h032] = 16'h7000;  // STP
    mem[12'h033] = 16'h1050;  // STA 0x050
    mem[12'hFFF] = 16'hC000;  // non-MU0

    reset      = 1'b1;
    skipstatus = 1'b0;
    accdata    = 16'h0000;

    // Reset held for two cycles
    step();
    check_strobes("rst_cycle", 1'b1, 1'b0, 1'b0, 1'b0);
    check("rst_memwr_accwen", {30'h0, memwr, accwen}, 32'h0);
    check("rst_instr", instruction, 32'h0000);
    check("rst_addr", addr, 32'h000);
    step();
    reset = 1'b0;
    #1;
    check_strobes("c0", 1'b1, 1'b0, 1'b0, 1'b0);
    check("c0_addr", addr, 32'h000);
    check("c0_pc", pc, 32'h000);

    // LDA 5
    step();
    check_strobes("lda_e1", 1'b0, 1'b1, 1'b0, 1'b0);
    check("lda_e1_addr", addr, 32'h005);
    check("lda_e1_instr", instruction, 32'h0005);
    check("lda_e1_accwen", accwen, 32'h0);
    step();
    check_strobes("lda_e2", 1'b0, 1'b0, 1'b1, 1'b0);
    check("lda_e2_operand", operand, 32'h1234);
    check("lda_e2_accwen", accwen, 32'h1);
    check("lda_e2_pc", pc, 32'h001);

    // STA 0x010
    step();
    accdata = 16'hBEEF;
    #1;
    check_strobes("sta_f", 1'b1, 1'b0, 1'b0, 1'b0);
    check("sta_f_addr", addr, 32'h001);
    check("sta_f_memwr", memwr, 32'h0);
    step();
    check_strobes("sta_e1", 1'b0, 1'b1, 1'b0, 1'b0);
    check("sta_e1_memwr", memwr, 32'h1);
    check("sta_e1_addr", addr, 32'h010);
    step();
    check_strobes("sta_next", 1'b1, 1'b0, 1'b0, 1'b0);
    check("sta_next_memwr", memwr, 32'h0);
    check("sta_next_addr", addr, 32'h002);
    check("sta_mem", mem[12'h010], 32'hBEEF);

    // JEQ taken, JEQ not taken, JMI taken
    accdata = 16'h0000;
    step();
    step();
    check("jeq_taken_pc", pc, 32'h020);
    check("jeq_taken_addr", addr, 32'h020);
    accdata = 16'h0001;
    step();
    step();
    check("jeq_not_pc", pc, 32'h021);
    accdata = 16'h8000;
    step();
    step();
    check("jmi_taken_pc", pc, 32'h030);

    // Skipped ADD 7
    accdata = 16'h0000;
    step();
    skipstatus = 1'b1;
    #1;
    check_strobes("skadd_e1", 1'b0, 1'b1, 1'b0, 1'b0);
    check("skadd_e1_accwen", accwen, 32'h0);
    check("skadd_e1_addr", addr, 32'h007);
    step();
    check_strobes("skadd_e2", 1'b0, 1'b0, 1'b1, 1'b0);
    check("skadd_e2_accwen", accwen, 32'h0);
    skipstatus = 1'b0;
    step();
    check_strobes("skadd_f", 1'b1, 1'b0, 1'b0, 1'b0);
    check("skadd_f_pc", pc, 32'h031);

    // Skipped JMP 0x100
    step();
    skipstatus = 1'b1;
    #1;
    check_strobes("skjmp_e1", 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    skipstatus = 1'b0;
    #1;
    check("skjmp_pc", pc, 32'h032);

    // Skipped STP
    step();
    skipstatus = 1'b1;
    step();
    skipstatus = 1'b0;
    #1;
    check_strobes("skstp_f", 1'b1, 1'b0, 1'b0, 1'b0);
    check("skstp_pc", pc, 32'h033);

    // Reset asserted during EXEC1 of STA 0x050
    accdata = 16'h5555;
    step();
    check("sta2_e1_memwr", memwr, 32'h1);
    reset = 1'b1;
    #1;
    check("rst_e1_memwr", memwr, 32'h0);
    check_strobes("rst_e1", 1'b1, 1'b0, 1'b0, 1'b0);
    check("rst_e1_addr", addr, 32'h000);
    step();
    reset = 1'b0;
    #1;
    check_strobes("rst_e1_after", 1'b1, 1'b0, 1'b0, 1'b0);
    check("rst_e1_after_pc", pc, 32'h000);
    check("rst_e1_nowrite", mem[12'h050], 32'h0000);

    // STP then sticky HALT
    mem[12'h000] = 16'h7000;
    step();
    check_strobes("stp_e1", 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    for (int i = 0; i < 10; i++) begin
      check_strobes($sformatf("halt%0d", i), 1'b0, 1'b0, 1'b0, 1'b1);
      check($sformatf("halt%0d_pc", i), pc, 32'h001);
      check($sformatf("halt%0d_wen", i), {30'h0, memwr, accwen}, 32'h0);
      step();
    end

    // Reset out of HALT, then JMP 0xFFF and wrap on a non-MU0 fetch
    mem[12'h000] = 16'h4FFF;
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    check_strobes("halt_rst", 1'b1, 1'b0, 1'b0, 1'b0);
    check("halt_rst_pc", pc, 32'h000);
    check("halt_rst_instr", instruction, 32'h0000);
    step();
    step();
    check("wrap_f_pc", pc, 32'hFFF);
    check("wrap_f_addr", addr, 32'hFFF);
    step();
    check_strobes("wrap_e1", 1'b0, 1'b1, 1'b0, 1'b0);
    check("wrap_e1_pc", pc, 32'h000);
    check("wrap_e1_instr", instruction, 32'hC000);
    check("wrap_e1_wen", {30'h0, memwr, accwen}, 32'h0);
    step();
    check_strobes("wrap_next", 1'b1, 1'b0, 1'b0, 1'b0);
    check("wrap_next_addr", addr, 32'h000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
